// File: rtl/bclk_training_ctrl.sv
// -----------------------------------------------------------------------------
// bclk_training_ctrl
//
// Fabric-side controller for the LPDDR3 BCLK training lane (FAB_CLK domain).
// Reloads the IOD input delay line, then sweeps it one tap at a time. At each
// tap it clears the eye-monitor flags, waits for the line to settle, and
// observes RX_DATA and the early/late flags. It finds the first run of at least
// MIN_WINDOW contiguous passing taps, then reloads the line and steps it to
// the centre of that run.
//
// Ports
//   FAB_CLK                 in   fabric clock (IOD RX_CLK domain)
//   SYNC_RST                in   synchronous active-high reset
//   TRAIN_START             in   one-cycle start request, ignored while busy
//   RX_DATA[7:0]            in   deserialised BCLK word
//   EYE_MONITOR_EARLY       in   IOD early flag (sticky until cleared)
//   EYE_MONITOR_LATE        in   IOD late flag (sticky until cleared)
//   DELAY_LINE_OUT_OF_RANGE in   IOD delay-line limit reached
//   DELAY_LINE_LOAD         out  one-cycle pulse, reload delay line to tap 0
//   DELAY_LINE_MOVE         out  one-cycle pulse, move one tap
//   DELAY_LINE_DIRECTION    out  1 (increment) whenever MOVE is high
//   EYE_MONITOR_CLEAR_FLAGS out  one-cycle pulse
//   BUSY                    out  training in progress
//   TRAIN_DONE              out  sticky, centring complete
//   TRAIN_ERR               out  sticky, no valid window found
//   TAP_COUNT[7:0]          out  final tap when done, else current sweep tap
//   DBG_STATE[3:0]          out  current FSM state encoding (debug)
//
// Handshake: TRAIN_START is sampled only in IDLE. Each pulse output is high
// for exactly one FAB_CLK cycle. No two of LOAD, MOVE and CLEAR_FLAGS are
// high in the same cycle.
// -----------------------------------------------------------------------------
module bclk_training_ctrl #(
  parameter int          SETTLE_CYCLES = 16,
  parameter int          SAMPLE_CYCLES = 32,
  parameter int          MAX_TAPS      = 128,
  parameter int          MIN_WINDOW    = 4,
  parameter logic [7:0]  PATTERN       = 8'h55
) (
  input  logic       FAB_CLK,
  input  logic       SYNC_RST,
  input  logic       TRAIN_START,
  input  logic [7:0] RX_DATA,
  input  logic       EYE_MONITOR_EARLY,
  input  logic       EYE_MONITOR_LATE,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       EYE_MONITOR_CLEAR_FLAGS,
  output logic       BUSY,
  output logic       TRAIN_DONE,
  output logic       TRAIN_ERR,
  output logic [7:0] TAP_COUNT,
  output logic [3:0] DBG_STATE
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_CLEAR  = 4'd2,
    S_SETTLE = 4'd3,
    S_SAMPLE = 4'd4,
    S_EVAL   = 4'd5,
    S_STEP   = 4'd6,
    S_CLOAD  = 4'd7,
    S_CMOVE  = 4'd8,
    S_CGAP   = 4'd9,
    S_DONE   = 4'd10,
    S_ERR    = 4'd11
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_CYCLES - 1);
  localparam logic [7:0]  LAST_TAP    = 8'(MAX_TAPS - 1);
  localparam logic [8:0]  MIN_W       = 9'(MIN_WINDOW);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_tap;
  logic [7:0]  r_start;
  logic [7:0]  r_end;
  logic [8:0]  r_run;
  logic        r_fail;
  logic [7:0]  r_prev;
  logic [7:0]  r_mcnt;
  logic        r_load;
  logic        r_move;
  logic        r_dir;
  logic        r_clr;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_tap_count;

  logic        w_word_bad;
  logic        w_changed;
  logic        w_sample_fail;
  logic        w_pass;
  logic        w_run_ok;
  logic [8:0]  w_run_next;
  logic [7:0]  w_start_next;
  logic        w_last;
  logic [8:0]  w_sum;
  logic [7:0]  w_centre;

  // Either polarity of the BCLK word is a valid lock.
  assign w_word_bad    = (RX_DATA != PATTERN) && (RX_DATA != ~PATTERN);
  // The first SAMPLE cycle has no predecessor within this tap.
  assign w_changed     = (r_cnt != 16'd0) && (RX_DATA != r_prev);
  assign w_sample_fail = w_word_bad | w_changed | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;

  assign w_pass       = ~r_fail;
  assign w_run_ok     = (r_run >= MIN_W);
  assign w_run_next   = w_pass ? (r_run + 9'd1) : (w_run_ok ? r_run : 9'd0);
  assign w_start_next = (w_pass && (r_run == 9'd0)) ? r_tap : r_start;
  assign w_last       = (r_tap == LAST_TAP) || DELAY_LINE_OUT_OF_RANGE;

  // Sum in 9 bits so taps near 255 do not wrap before the halving.
  assign w_sum    = {1'b0, r_start} + {1'b0, r_end};
  assign w_centre = w_sum[8:1];

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_tap       <= 8'd0;
      r_start     <= 8'd0;
      r_end       <= 8'd0;
      r_run       <= 9'd0;
      r_fail      <= 1'b0;
      r_prev      <= 8'd0;
      r_mcnt      <= 8'd0;
      r_load      <= 1'b0;
      r_move      <= 1'b0;
      r_dir       <= 1'b0;
      r_clr       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_tap_count <= 8'd0;
    end else begin
      // Pulse outputs default low; a transition raises one for the next cycle.
      r_load <= 1'b0;
      r_move <= 1'b0;
      r_dir  <= 1'b0;
      r_clr  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_tap   <= 8'd0;
          r_start <= 8'd0;
          r_run   <= 9'd0;
          if (TRAIN_START) begin
            r_state     <= S_LOAD;
            r_load      <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_tap_count <= 8'd0;
          end
        end
        S_LOAD: begin
          r_state <= S_CLEAR;
          r_clr   <= 1'b1;
        end
        S_CLEAR: begin
          r_state <= S_SETTLE;
          r_cnt   <= 16'd0;
        end
        S_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_state <= S_SAMPLE;
            r_cnt   <= 16'd0;
            r_fail  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_SAMPLE: begin
          r_prev <= RX_DATA;
          r_fail <= r_fail | w_sample_fail;
          if (r_cnt == SAMPLE_LAST) begin
            r_state <= S_EVAL;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_EVAL: begin
          r_run   <= w_run_next;
          r_start <= w_start_next;
          if (!w_pass && w_run_ok) begin
            // Window closed by this failing tap.
            r_end   <= r_tap - 8'd1;
            r_state <= S_CLOAD;
            r_load  <= 1'b1;
          end else if (w_last) begin
            if (w_run_next >= MIN_W) begin
              // Window still open at the end of the usable range.
              r_end   <= r_tap;
              r_state <= S_CLOAD;
              r_load  <= 1'b1;
            end else begin
              r_state     <= S_ERR;
              r_err       <= 1'b1;
              r_busy      <= 1'b0;
              r_tap_count <= r_tap;
            end
          end else begin
            r_state <= S_STEP;
            r_move  <= 1'b1;
            r_dir   <= 1'b1;
          end
        end
        S_STEP: begin
          r_tap       <= r_tap + 8'd1;
          r_tap_count <= r_tap + 8'd1;
          r_state     <= S_CLEAR;
          r_clr       <= 1'b1;
        end
        S_CLOAD: begin
          r_mcnt <= 8'd0;
          if (w_centre == 8'd0) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_tap_count <= w_centre;
          end else begin
            r_state <= S_CMOVE;
            r_move  <= 1'b1;
            r_dir   <= 1'b1;
          end
        end
        S_CMOVE: begin
          r_mcnt  <= r_mcnt + 8'd1;
          r_state <= S_CGAP;
        end
        S_CGAP: begin
          // The gap cycle keeps MOVE pulses from ever being adjacent.
          if (r_mcnt == w_centre) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_tap_count <= w_centre;
          end else begin
            r_state <= S_CMOVE;
            r_move  <= 1'b1;
            r_dir   <= 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        S_ERR:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign DELAY_LINE_LOAD         = r_load;
  assign DELAY_LINE_MOVE         = r_move;
  assign DELAY_LINE_DIRECTION    = r_dir;
  assign EYE_MONITOR_CLEAR_FLAGS = r_clr;
  assign BUSY                    = r_busy;
  assign TRAIN_DONE              = r_done;
  assign TRAIN_ERR               = r_err;
  assign TAP_COUNT               = r_tap_count;
  assign DBG_STATE               = r_state;

endmodule

// File: tb/tb_bclk_training_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bclk_training_ctrl
//
// Bench for bclk_training_ctrl with SETTLE=4, SAMPLE=8, MAX_TAPS=32,
// MIN_WINDOW=3, PATTERN=8'h55. A behavioural IOD model follows LOAD/MOVE to
// track the delay-line tap and produces RX_DATA, eye flags and out-of-range
// from a per-scenario description. Expected outcomes come from a small
// reference model and are queued when each training run is started.
// -----------------------------------------------------------------------------
module tb_bclk_training_ctrl;

  localparam int S       = 4;
  localparam int N       = 8;
  localparam int MAXT    = 32;
  localparam int MINW    = 3;
  localparam int PER_TAP = 3 + S + N;
  localparam int W       = 48;
  localparam int BUDGET  = 2000;

  // ---------------- clock / reset ----------------
  logic       FAB_CLK = 1'b0;
  logic       SYNC_RST = 1'b1;
  logic       TRAIN_START = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       EYE_MONITOR_EARLY = 1'b0;
  logic       EYE_MONITOR_LATE = 1'b0;
  logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       EYE_MONITOR_CLEAR_FLAGS;
  logic       BUSY;
  logic       TRAIN_DONE;
  logic       TRAIN_ERR;
  logic [7:0] TAP_COUNT;
  logic [3:0] DBG_STATE;

  always #5 FAB_CLK = ~FAB_CLK;

  bclk_training_ctrl #(
    .SETTLE_CYCLES(S),
    .SAMPLE_CYCLES(N),
    .MAX_TAPS(MAXT),
    .MIN_WINDOW(MINW),
    .PATTERN(8'h55)
  ) dut (
    .FAB_CLK(FAB_CLK),
    .SYNC_RST(SYNC_RST),
    .TRAIN_START(TRAIN_START),
    .RX_DATA(RX_DATA),
    .EYE_MONITOR_EARLY(EYE_MONITOR_EARLY),
    .EYE_MONITOR_LATE(EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
    .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
    .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
    .BUSY(BUSY),
    .TRAIN_DONE(TRAIN_DONE),
    .TRAIN_ERR(TRAIN_ERR),
    .TAP_COUNT(TAP_COUNT),
    .DBG_STATE(DBG_STATE)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- IOD model and pulse monitor ----------------
  logic [31:0] data_mask = 32'd0;
  int eye_tap = -1;
  int oor_tap = 1000;
  int mdl_tap = 0;
  int clr_age = 1000;
  int load_cnt = 0;
  int busy_cnt = 0;
  int prev_seg_moves = 0;
  int last_seg_moves = 0;
  int adj_err = 0;
  int excl_err = 0;
  int dir_err = 0;
  bit prev_move = 1'b0;

  always @(negedge FAB_CLK) begin
    logic [7:0] g;
    if ((int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE) + int'(EYE_MONITOR_CLEAR_FLAGS)) > 1) excl_err++;
    if (DELAY_LINE_MOVE && prev_move) adj_err++;
    if (DELAY_LINE_MOVE && !DELAY_LINE_DIRECTION) dir_err++;
    prev_move = DELAY_LINE_MOVE;
    if (BUSY) busy_cnt++;
    if (DELAY_LINE_LOAD) begin
      load_cnt++;
      mdl_tap = 0;
      prev_seg_moves = last_seg_moves;
      last_seg_moves = 0;
    end else if (DELAY_LINE_MOVE) begin
      last_seg_moves++;
      if (DELAY_LINE_DIRECTION) mdl_tap++;
      else mdl_tap--;
    end
    if (EYE_MONITOR_CLEAR_FLAGS) clr_age = 0;
    else if (clr_age < 1000) clr_age++;
    // Age 7 falls in the third SAMPLE cycle after a flag clear.
    EYE_MONITOR_EARLY = (mdl_tap == eye_tap) && (clr_age == 7);
    DELAY_LINE_OUT_OF_RANGE = (mdl_tap >= oor_tap);
    if (mdl_tap >= 0 && mdl_tap < MAXT && data_mask[mdl_tap]) begin
      RX_DATA = mdl_tap[0] ? 8'hAA : 8'h55;
    end else begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'h55 || g == 8'hAA) g = g ^ 8'h01;
      RX_DATA = g;
    end
  end

  // ---------------- reference model ----------------
  // Packed result: [47] err, [39:32] final tap, [31:24] sweep moves,
  // [23:16] centring moves, [15:0] busy cycles.
  function automatic logic [W-1:0] model_expect(input logic [31:0] pm, input int oor_t);
    int run, st, en, ntaps, c;
    bit fin, err;
    logic [W-1:0] r;
    run = 0; st = 0; en = 0; ntaps = 0; fin = 0; err = 0;
    for (int t = 0; t < MAXT; t++) begin
      if (!fin) begin
        ntaps = t + 1;
        if (pm[t]) begin
          if (run == 0) st = t;
          run++;
        end else if (run >= MINW) begin
          en = t - 1;
          fin = 1;
        end else begin
          run = 0;
        end
        if (!fin && (t == MAXT - 1 || t >= oor_t)) begin
          if (run >= MINW) en = t;
          else err = 1;
          fin = 1;
        end
      end
    end
    c = (st + en) / 2;
    r = '0;
    r[47] = err;
    r[31:24] = 8'(ntaps - 1);
    if (err) begin
      r[39:32] = 8'(ntaps - 1);
      r[15:0]  = 16'(PER_TAP * ntaps);
    end else begin
      r[39:32] = 8'(c);
      r[23:16] = 8'(c);
      r[15:0]  = 16'(PER_TAP * ntaps + 1 + 2 * c);
    end
    return r;
  endfunction

  function automatic logic [31:0] range_mask(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // ---------------- driver + scoreboard ----------------
  task automatic run_training(input string name, input int ign_cyc,
                              output bit busy1, output bit load1);
    int l0, b0;
    bit got;
    logic [31:0] pm;
    logic [W-1:0] exp;
    pm = data_mask;
    if (eye_tap >= 0) pm[eye_tap] = 1'b0;
    exp_q.push_back(model_expect(pm, oor_tap));
    @(negedge FAB_CLK); #1;
    l0 = load_cnt;
    b0 = busy_cnt;
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK); #1;
    TRAIN_START = 1'b0;
    busy1 = BUSY;
    load1 = DELAY_LINE_LOAD;
    got = 0;
    for (int cyc = 1; cyc <= BUDGET && !got; cyc++) begin
      @(negedge FAB_CLK); #1;
      if (ign_cyc != 0 && cyc == ign_cyc) TRAIN_START = 1'b1;
      else TRAIN_START = 1'b0;
      if (TRAIN_DONE || TRAIN_ERR) got = 1;
    end
    TRAIN_START = 1'b0;
    exp = exp_q.pop_front();
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s.timeout: no TRAIN_DONE/TRAIN_ERR within %0d cycles, required completion", name, BUDGET);
    end else begin
      checks++;
      if (TRAIN_ERR !== exp[47]) begin
        errors++; $display("FAIL %s.train_err: got %b expected %b", name, TRAIN_ERR, exp[47]);
      end
      checks++;
      if (TRAIN_DONE !== !exp[47]) begin
        errors++; $display("FAIL %s.train_done: got %b expected %b", name, TRAIN_DONE, !exp[47]);
      end
      checks++;
      if (TAP_COUNT !== exp[39:32]) begin
        errors++; $display("FAIL %s.tap_count: got %0d expected %0d", name, TAP_COUNT, exp[39:32]);
      end
      checks++;
      if (mdl_tap != int'(exp[39:32])) begin
        errors++; $display("FAIL %s.parked_tap: got %0d expected %0d", name, mdl_tap, exp[39:32]);
      end
      checks++;
      if ((load_cnt - l0) != (exp[47] ? 1 : 2)) begin
        errors++; $display("FAIL %s.load_pulses: got %0d expected %0d", name, load_cnt - l0, exp[47] ? 1 : 2);
      end
      checks++;
      if ((exp[47] ? last_seg_moves : prev_seg_moves) != int'(exp[31:24])) begin
        errors++; $display("FAIL %s.sweep_moves: got %0d expected %0d", name,
                           exp[47] ? last_seg_moves : prev_seg_moves, exp[31:24]);
      end
      if (!exp[47]) begin
        checks++;
        if (last_seg_moves != int'(exp[23:16])) begin
          errors++; $display("FAIL %s.centre_moves: got %0d expected %0d", name, last_seg_moves, exp[23:16]);
        end
      end
      checks++;
      if ((busy_cnt - b0) != int'(exp[15:0])) begin
        errors++; $display("FAIL %s.busy_cycles: got %0d expected %0d", name, busy_cnt - b0, exp[15:0]);
      end
    end
    repeat (2) @(negedge FAB_CLK);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    SYNC_RST = 1'b1;
    repeat (3) @(negedge FAB_CLK);
    #1;
    checks++;
    if ({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
         BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT} !== 15'd0) begin
      errors++; $display("FAIL reset.outputs: got %b expected all zero",
        {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
         BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT});
    end
    checks++;
    if (DBG_STATE !== 4'd0) begin
      errors++; $display("FAIL reset.state: got %0d expected 0", DBG_STATE);
    end
    // Start coincident with reset must be dropped.
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK); #1;
    TRAIN_START = 1'b0;
    checks++;
    if ({BUSY, DELAY_LINE_LOAD} !== 2'b00) begin
      errors++; $display("FAIL reset.start_with_reset: got busy,load=%b expected 00", {BUSY, DELAY_LINE_LOAD});
    end
    SYNC_RST = 1'b0;
    repeat (2) @(negedge FAB_CLK);
    #1;
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL reset.idle_after_release: got busy=%b expected 0", BUSY);
    end
  endtask

  task automatic test_clean_window();
    bit b, l;
    data_mask = range_mask(10, 20); eye_tap = -1; oor_tap = 1000;
    run_training("clean", 0, b, l);
    checks++;
    if (b !== 1'b1 || l !== 1'b1) begin
      errors++; $display("FAIL clean.start_response: got busy=%b load=%b expected 1 1", b, l);
    end
    checks++;
    if (TRAIN_DONE !== 1'b1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL clean.sticky_done: got done=%b busy=%b expected 1 0", TRAIN_DONE, BUSY);
    end
  endtask

  task automatic test_narrow_wide();
    bit b, l;
    data_mask = range_mask(4, 5) | range_mask(12, 25); eye_tap = -1; oor_tap = 1000;
    run_training("narrow_wide", 0, b, l);
  endtask

  task automatic test_eye_flag();
    bit b, l;
    data_mask = range_mask(8, 20); eye_tap = 14; oor_tap = 1000;
    run_training("eye_flag", 0, b, l);
    eye_tap = -1;
  endtask

  task automatic test_out_of_range();
    bit b, l;
    data_mask = range_mask(20, 31); eye_tap = -1; oor_tap = 23;
    run_training("out_of_range", 0, b, l);
    oor_tap = 1000;
  endtask

  task automatic test_no_window();
    bit b, l;
    data_mask = 32'd0; eye_tap = -1; oor_tap = 1000;
    run_training("no_window", 0, b, l);
  endtask

  task automatic test_reset_mid();
    int l0;
    bit got;
    data_mask = range_mask(10, 20); eye_tap = -1; oor_tap = 1000;
    @(negedge FAB_CLK); #1;
    TRAIN_START = 1'b1;
    @(negedge FAB_CLK); #1;
    TRAIN_START = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < BUDGET && !got; cyc++) begin
      if (mdl_tap == 6) got = 1;
      else begin @(negedge FAB_CLK); #1; end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL reset_mid.reach_tap6: got tap %0d expected 6", mdl_tap);
    end
    // From the STEP cycle: CLEAR, 4 SETTLE, then into SAMPLE.
    repeat (7) @(negedge FAB_CLK);
    #1;
    checks++;
    if (BUSY !== 1'b1) begin
      errors++; $display("FAIL reset_mid.busy_before: got %b expected 1", BUSY);
    end
    SYNC_RST = 1'b1;
    @(negedge FAB_CLK); #1;
    SYNC_RST = 1'b0;
    checks++;
    if ({DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
         BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT} !== 15'd0) begin
      errors++; $display("FAIL reset_mid.outputs: got %b expected all zero",
        {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS,
         BUSY, TRAIN_DONE, TRAIN_ERR, TAP_COUNT});
    end
    l0 = load_cnt;
    repeat (6) @(negedge FAB_CLK);
    #1;
    checks++;
    if (load_cnt != l0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_mid.quiet_after: got loads=%0d busy=%b expected 0 0", load_cnt - l0, BUSY);
    end
  endtask

  task automatic test_ignore_restart();
    bit b, l;
    data_mask = range_mask(10, 20); eye_tap = -1; oor_tap = 1000;
    // Extra start pulse 40 cycles into the sweep; the scoreboard's busy-cycle
    // and move counts show whether it disturbed the run.
    run_training("restart_ignore", 40, b, l);
    checks++;
    if (l !== 1'b1 || b !== 1'b1) begin
      errors++; $display("FAIL restart.begins_with_load: got load=%b busy=%b expected 1 1", l, b);
    end
  endtask

  task automatic test_pulse_rules();
    checks++;
    if (adj_err != 0) begin
      errors++; $display("FAIL rules.adjacent_moves: got %0d expected 0", adj_err);
    end
    checks++;
    if (excl_err != 0) begin
      errors++; $display("FAIL rules.exclusive_pulses: got %0d expected 0", excl_err);
    end
    checks++;
    if (dir_err != 0) begin
      errors++; $display("FAIL rules.direction: got %0d expected 0", dir_err);
    end
  endtask

  initial begin
    test_reset();
    test_clean_window();
    test_narrow_wide();
    test_eye_flag();
    test_out_of_range();
    test_no_window();
    test_reset_mid();
    test_ignore_restart();
    test_pulse_rules();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
